load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of request and memory addresses.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  CPU memory request present this cycle.
REQ-005 SHALL have port req_write  input  1  1=store, 0=load.
REQ-006 SHALL have port req_size  input  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-007 SHALL have port req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-008 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port stall  output  1  requester holds all req_* stable and does not advance.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse; load data valid.
REQ-012 SHALL have port rsp_rdata  output  32  extended load result.
REQ-013 SHALL have port err  output  1  one-cycle pulse; misaligned or illegal request.
REQ-014 SHALL have ports mem_read / mem_write  output  1 each  data-memory strobes.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word-aligned address, with bits [1:0] forced to 00.
REQ-016 SHALL have ports mem_wdata  output  32  and  mem_rdata  input  32  memory data; memory read is combinational and memory write is synchronous.

Function
REQ-017 SHALL use FSM states IDLE and WRITE; requests are accepted only in IDLE while req_valid=1.
REQ-018 SHALL treat a request as misaligned when half has addr[0]=1, word has addr[1:0]!=00, or size=11.
- Misaligned or illegal request: no mem strobe; err=1 in the next cycle; no rsp_valid.
REQ-019 SHALL handle a load as follows:
- Acceptance cycle: mem_read=1.
- At the next edge, register the extracted lane into rsp_rdata.
- rsp_valid=1 for exactly the next cycle.
- stall=0 throughout; latency is 1 cycle.
REQ-020 SHALL extract lanes little-endian: byte lane n = mem_rdata[8n+7:8n]; half lane = addr[1].
- Extension per req_signed.
REQ-021 SHALL complete a word store in its acceptance cycle: mem_write=1, mem_wdata=req_wdata, stall=0.
REQ-022 SHALL perform a byte/half store as a read-modify-write:
- Acceptance cycle: mem_read=1 and stall=1; latch the merged word (mem_rdata with the target lanes replaced by req_wdata low bits) and the address; go to WRITE.
- WRITE: mem_write=1 with the latched word and address; stall=0; return to IDLE.
REQ-023 SHALL ignore req_valid in WRITE; the requester's next request is accepted in the following IDLE cycle.
REQ-024 SHALL hold mem_read and mem_write at 0 when no request is accepted; the two strobes SHALL never both be 1.
REQ-025 SHALL drive mem_wdata=0 whenever mem_write=0.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, rsp_valid=0, rsp_rdata=0, err=0, latched word/address=0, stall=0 and mem strobes 0.
REQ-027 SHALL, when rst is asserted in WRITE, abandon the pending store so that no mem_write occurs.

Structure
REQ-028 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in shared package lsu_pkg.
REQ-029 SHALL implement lane extraction and store merging in one combinational sub-module, lsu_byte_lane.

Verification
REQ-030 Word load, mem word 0x8899AABC at addr 0x10 -> rsp_valid one cycle later, rsp_rdata=0x8899AABC, stall never high.
REQ-031 Signed byte load at 0x13, same word -> 0xFFFFFF88; unsigned -> 0x00000088; signed half at 0x12 -> 0xFFFF8899.
REQ-032 Byte store 0x55 at 0x11, mem 0x8899AABC -> stall high 1 cycle, then mem_write with data 0x889955BC at mem_addr 0x10.
REQ-033 Word store 0x12345678 at 0x20 -> mem_write same cycle, no stall; subsequent load at 0x20 returns 0x12345678.
REQ-034 Half load at 0x11 and word store at 0x22 -> err pulse each, no mem_read or mem_write, no rsp_valid.
REQ-035 rst asserted during WRITE of a half store -> no mem_write; memory word unchanged; state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges store data into a memory word for byte/half read-modify-write.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed lane (little-endian) and sign/zero extend it
    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{is_signed & lane_half[15]}}, lane_half};
            default: load_data = rdata;
        endcase
    end

    // Replace the target lanes of the memory word with the low store-data bits
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: 1-cycle loads, single-cycle word stores, and two-cycle
// read-modify-write for byte/half stores against a word-wide memory.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    lsu_state_t        next_state;
    logic [31:0]       held_word;
    logic [ADDR_W-1:0] held_addr;
    logic [ADDR_W-1:0] word_addr;
    logic              misaligned;
    logic              accept;
    logic              load_go;
    logic              store_word_go;
    logic              rmw_go;
    logic              bad_go;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    lsu_byte_lane u_lane (
        .rdata     (mem_rdata),
        .addr_lo   (req_addr[1:0]),
        .size      (req_size),
        .is_signed (req_signed),
        .wdata     (req_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Classify the incoming request; only IDLE accepts, never during reset
    always_comb begin
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        accept        = (state == IDLE) && req_valid && !rst;
        bad_go        = accept && misaligned;
        load_go       = accept && !misaligned && !req_write;
        store_word_go = accept && !misaligned && req_write && (req_size == SZ_WORD);
        rmw_go        = accept && !misaligned && req_write && (req_size != SZ_WORD);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: RMW stores take one extra WRITE cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rmw_go) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes and stall; reset suppresses everything, including a pending WRITE
    always_comb begin
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = word_addr;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (load_go) begin
                        mem_read = 1'b1;
                    end else if (store_word_go) begin
                        mem_write = 1'b1;
                        mem_wdata = req_wdata;
                    end else if (rmw_go) begin
                        mem_read = 1'b1;
                        stall    = 1'b1;
                    end
                end
                WRITE: begin
                    mem_write = 1'b1;
                    mem_wdata = held_word;
                    mem_addr  = held_addr;
                end
                default: ;
            endcase
        end
    end

    // Response, error pulse and RMW latches
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= 1'b0;
            held_word <= '0;
            held_addr <= '0;
        end else begin
            rsp_valid <= load_go;
            err       <= bad_go;
            if (load_go)
                rsp_rdata <= load_data;
            if (rmw_go) begin
                held_word <= merged;
                held_addr <= word_addr;
            end
        end
    end

endmodule
